systolic_mv_array: RTL and testbench

- Parametrised N x N weight-stationary systolic array computing one matrix-vector product per input vector: y[j] = sum over k of a[k]*W[k][j].
- Successor to the fixed 4x4 constant-weight array, adding:
  - runtime-loadable weights;
  - internal input skew and output deskew, so callers present and receive whole aligned vectors;
  - valid/ready handshakes;
  - optional signed arithmetic.
- Sits between the activation buffer and the accumulator/writeback stage.

---
 rtl/systolic_mv_array_if.sv | 33 +++
 rtl/systolic_mv_array.sv | 160 ++++++++++++++++
 tb/tb_systolic_mv_array.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mv_array_if.sv
// Bus bundle for systolic_mv_array: weight-row handshake, activation-vector
// handshake, aligned result vector and status flags.
//   wt_valid/wt_ready/wt_in    : one weight row W[k][*] per handshake, lane j = W[k][j]
//   act_valid/act_ready/act_in : one activation vector per handshake, lane k = a[k]
//   out_valid/y_out            : one-cycle pulse per result, lane j = y[j]
//   busy, err_drop             : vectors in flight / sticky dropped-activation flag
// master = producer/consumer side (activation buffer, writeback), slave = array.
interface systolic_mv_array_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
);
  logic                         wt_valid;
  logic                         wt_ready;
  logic [N-1:0][DATA_W-1:0]     wt_in;
  logic                         act_valid;
  logic                         act_ready;
  logic [N-1:0][DATA_W-1:0]     act_in;
  logic                         out_valid;
  logic [N-1:0][ACC_W-1:0]      y_out;
  logic                         busy;
  logic                         err_drop;

  modport master (
    output wt_valid, wt_in, act_valid, act_in,
    input  wt_ready, act_ready, out_valid, y_out, busy, err_drop
  );

  modport slave (
    input  wt_valid, wt_in, act_valid, act_in,
    output wt_ready, act_ready, out_valid, y_out, busy, err_drop
  );
endinterface

// File: rtl/systolic_mv_array.sv
// Weight-stationary N x N systolic matrix-vector engine: y[j] = sum_k a[k]*W[k][j].
// Ports:
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset (clears weights, pipeline, FSM)
//   bus   : systolic_mv_array_if.slave (weight load, activation in, result out, status)
// PE[j][k] holds W[k][j]; activation lane k runs down column k, partial sum for
// output j runs across row j. Inputs are skewed and outputs deskewed internally
// so a vector accepted at edge t appears on y_out right after edge t+2N.

// Single MAC cell: registered partial sum, operands extended to ACC_W first so
// the product and sum both wrap modulo 2^ACC_W.
module systolic_mv_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [ACC_W-1:0]  psum_i,
  output logic [ACC_W-1:0]  psum_o
);
  logic [ACC_W-1:0] a_ext, w_ext, psum_d, psum_q;

  assign a_ext  = {{(ACC_W-DATA_W){(SIGNED != 0) && a_i[DATA_W-1]}}, a_i};
  assign w_ext  = {{(ACC_W-DATA_W){(SIGNED != 0) && w_i[DATA_W-1]}}, w_i};
  assign psum_d = psum_i + a_ext * w_ext;

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) psum_q <= '0;
    else        psum_q <= psum_d;

  assign psum_o = psum_q;
endmodule

module systolic_mv_array #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,   // must be >= 2*DATA_W
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst_b,
  systolic_mv_array_if.slave bus
);
  localparam int STAGES = 2*N;
  localparam int RC_W   = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(2*N+1);

  typedef enum logic [1:0] {NOWT, LOAD, READY} state_e;

  state_e                         state_q, state_d;
  logic [RC_W-1:0]                rc_q, rc_d, row;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           err_q, err_d;
  logic                           wt_hs, act_hs;
  logic [STAGES:0]                vld_pipe;
  logic [N-1:0][N-1:0][DATA_W-1:0] w_q;   // [k][j]
  logic [N-1:0][N-1:0][DATA_W-1:0] pe_a;  // [j][k]
  logic [N-1:0][N:0][ACC_W-1:0]    ps;    // [j][k], ps[j][0] = 0
  logic [N-1:0][ACC_W-1:0]         row_y, y_q;

  // Next state, handshakes. A weight handshake always wins over an activation.
  always_comb begin
    state_d       = state_q;
    rc_d          = rc_q;
    row           = '0;
    bus.wt_ready  = (state_q != READY) || (cnt_q == '0);
    wt_hs         = bus.wt_valid && bus.wt_ready;
    bus.act_ready = (state_q == READY) && !wt_hs;
    act_hs        = bus.act_valid && bus.act_ready;
    if (wt_hs) begin
      // A load starting from NOWT or READY always restarts at row 0.
      row = (state_q == LOAD) ? rc_q : '0;
      if (row == RC_W'(N-1)) begin
        state_d = READY;
        rc_d    = '0;
      end else begin
        state_d = LOAD;
        rc_d    = row + RC_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (act_hs && !vld_pipe[STAGES])      cnt_d = cnt_q + CNT_W'(1);
    else if (!act_hs && vld_pipe[STAGES]) cnt_d = cnt_q - CNT_W'(1);
    err_d = err_q || (bus.act_valid && !bus.act_ready);
  end

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state_q  <= NOWT;
      rc_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      vld_pipe <= '0;
      y_q      <= '0;
      w_q      <= '0;
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], act_hs};
      if (vld_pipe[STAGES-1]) y_q <= row_y;
      if (wt_hs) w_q[row] <= bus.wt_in;
    end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.y_out     = y_q;
  assign bus.busy      = (cnt_q != '0);
  assign bus.err_drop  = err_q;

  // One delay chain per lane serves both the input skew (k stages) and the
  // column-to-column activation hop: PE[j][k] taps stage k+j.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [k+N-1:0][DATA_W-1:0] sk_q;
    always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) sk_q <= '0;
      else begin
        sk_q[0] <= act_hs ? bus.act_in[k] : '0;
        for (int s = 1; s < k+N; s++) sk_q[s] <= sk_q[s-1];
      end
    for (genvar j = 0; j < N; j++) begin : g_tap
      assign pe_a[j][k] = sk_q[k+j];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_row
    assign ps[j][0] = '0;
    for (genvar k = 0; k < N; k++) begin : g_col
      systolic_mv_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
        .clk    (clk),
        .rst_b  (rst_b),
        .a_i    (pe_a[j][k]),
        .w_i    (w_q[k][j]),
        .psum_i (ps[j][k]),
        .psum_o (ps[j][k+1])
      );
    end

    // Row j finishes j cycles after row 0; pad it so every lane lands together.
    localparam int D = N-1-j;
    if (D == 0) begin : g_nodsk
      assign row_y[j] = ps[j][N];
    end else begin : g_dsk
      logic [D-1:0][ACC_W-1:0] dk_q;
      always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) dk_q <= '0;
        else begin
          dk_q[0] <= ps[j][N];
          for (int s = 1; s < D; s++) dk_q[s] <= dk_q[s-1];
        end
      assign row_y[j] = dk_q[D-1];
    end
  end
endmodule

// File: tb/tb_systolic_mv_array.sv
module tb_systolic_mv_array;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic                 wt_valid = 1'b0, act_valid = 1'b0;
  logic [N-1:0][DW-1:0] wt_in = '0, act_in = '0;

  systolic_mv_array_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus_u ();
  systolic_mv_array_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus_s ();

  assign bus_u.wt_valid  = wt_valid;
  assign bus_u.wt_in     = wt_in;
  assign bus_u.act_valid = act_valid;
  assign bus_u.act_in    = act_in;
  assign bus_s.wt_valid  = wt_valid;
  assign bus_s.wt_in     = wt_in;
  assign bus_s.act_valid = act_valid;
  assign bus_s.act_in    = act_in;

  systolic_mv_array #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) u_dut (
    .clk(clk), .rst_b(rst_b), .bus(bus_u));
  systolic_mv_array #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_b(rst_b), .bus(bus_s));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef logic [N-1:0][AW-1:0] yvec_t;
  typedef struct { int due; yvec_t yu; yvec_t ys; } exp_t;

  int    Wm [N][N];   // [k][j], raw 0..255
  bit    m_full, m_loading, m_err;
  int    m_rows, m_inflight, cyc;
  exp_t  q [$];
  yvec_t last_u, last_s;

  function automatic longint sx(input int v);
    return (v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  function automatic yvec_t mv(input logic [N-1:0][DW-1:0] a, input bit sgn);
    yvec_t r;
    for (int j = 0; j < N; j++) begin
      longint s = 0;
      for (int k = 0; k < N; k++)
        s += sgn ? sx(int'(a[k])) * sx(Wm[k][j]) : longint'(a[k]) * longint'(Wm[k][j]);
      r[j] = s[AW-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    bit ewr, ear, ov, whs, acc;
    int r;
    exp_t e;
    if (!rst_b) begin
      foreach (Wm[k, j]) Wm[k][j] = 0;
      m_full = 0; m_loading = 0; m_err = 0; m_rows = 0; m_inflight = 0;
      q.delete(); last_u = '0; last_s = '0;
      chk("rst_wt_ready",  {bus_s.wt_ready,  bus_u.wt_ready},  2'b11);
      chk("rst_act_ready", {bus_s.act_ready, bus_u.act_ready}, 2'b00);
      chk("rst_out_valid", {bus_s.out_valid, bus_u.out_valid}, 2'b00);
      chk("rst_busy_err",  {bus_s.busy, bus_u.busy, bus_s.err_drop, bus_u.err_drop}, 4'b0);
      chk("rst_y_u", bus_u.y_out, '0);
      chk("rst_y_s", bus_s.y_out, '0);
    end else begin
      ewr = !m_full || (m_inflight == 0);
      ear = m_full && !(wt_valid && ewr);
      ov  = (q.size() > 0) && (q[0].due == cyc);
      chk("wt_ready",  {bus_s.wt_ready,  bus_u.wt_ready},  {ewr, ewr});
      chk("act_ready", {bus_s.act_ready, bus_u.act_ready}, {ear, ear});
      chk("busy",      {bus_s.busy, bus_u.busy}, {2{m_inflight != 0}});
      chk("err_drop",  {bus_s.err_drop, bus_u.err_drop}, {m_err, m_err});
      chk("out_valid", {bus_s.out_valid, bus_u.out_valid}, {ov, ov});
      if (ov) begin
        last_u = q[0].yu; last_s = q[0].ys;
        void'(q.pop_front());
      end
      chk("y_out_u", bus_u.y_out, last_u);
      chk("y_out_s", bus_s.y_out, last_s);
      // advance to the state after the coming edge
      whs = wt_valid && ewr;
      acc = act_valid && ear;
      if (act_valid && !ear) m_err = 1;
      if (acc) begin
        e.due = cyc + 2*N + 1;
        e.yu  = mv(act_in, 0);
        e.ys  = mv(act_in, 1);
        q.push_back(e);
      end
      if (whs) begin
        r = m_loading ? m_rows : 0;
        for (int j = 0; j < N; j++) Wm[r][j] = int'(wt_in[j]);
        if (r == N-1) begin m_full = 1; m_loading = 0; m_rows = 0; end
        else          begin m_full = 0; m_loading = 1; m_rows = r + 1; end
      end
      m_inflight += (acc ? 1 : 0) - (ov ? 1 : 0);
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; wt_valid = 0; act_valid = 0;
    repeat (2) tick();
    rst_b = 1'b1;
  endtask

  task automatic send_wt(input logic [N-1:0][DW-1:0] d);
    int n = 0;
    wt_valid = 1'b1; wt_in = d;
    @(negedge clk);
    while (!bus_u.wt_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("wt_ready_timeout", 0, 1);
    tick();
    wt_valid = 1'b0;
  endtask

  task automatic send_act(input logic [N-1:0][DW-1:0] d);
    int n = 0;
    act_valid = 1'b1; act_in = d;
    @(negedge clk);
    while (!bus_u.act_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("act_ready_timeout", 0, 1);
    tick();
    act_valid = 1'b0;
  endtask

  task automatic load_const(input logic [DW-1:0] v);
    logic [N-1:0][DW-1:0] d;
    for (int j = 0; j < N; j++) d[j] = v;
    for (int r = 0; r < N; r++) send_wt(d);
  endtask

  task automatic load_kp1();
    logic [N-1:0][DW-1:0] d;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) d[j] = DW'(r + 1);
      send_wt(d);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus_u.out_valid && n < 100) begin tick(); n++; end
    if (n >= 100) chk("out_valid_timeout", 0, 1);
  endtask

  function automatic logic [N-1:0][DW-1:0] rnd_vec();
    logic [N-1:0][DW-1:0] d;
    for (int j = 0; j < N; j++) d[j] = DW'($urandom);
    return d;
  endfunction

  function automatic logic [N-1:0][DW-1:0] splat(input int v);
    logic [N-1:0][DW-1:0] d;
    for (int j = 0; j < N; j++) d[j] = DW'(v);
    return d;
  endfunction

  initial begin
    logic [N-1:0][DW-1:0] d;
    int n, outs;
    repeat (3) tick();
    rst_b = 1'b1;

    // activation before any weights: dropped
    act_valid = 1'b1; act_in = splat(7);
    tick();
    act_valid = 1'b0;
    chk("early_act_err", bus_u.err_drop, 1);
    repeat (12) tick();
    do_reset();

    // load W[k][j]=k+1, single vector (1,2,3,4) -> 30 after 2N cycles
    load_kp1();
    for (int k = 0; k < N; k++) d[k] = DW'(k + 1);
    send_act(d);
    chk("busy_after_accept", bus_u.busy, 1);
    wait_out(n);
    chk("latency_2N", n, 2*N);
    for (int j = 0; j < N; j++) chk("y30", bus_u.y_out[j], 30);
    chk("busy_at_out", bus_u.busy, 1);
    tick();
    chk("busy_clear", bus_u.busy, 0);

    // streaming 10 back-to-back vectors -> 10v each, no gaps
    fork
      begin
        for (int v = 1; v <= 10; v++) begin
          act_valid = 1'b1; act_in = splat(v);
          tick();
        end
        act_valid = 1'b0;
      end
      begin
        int m;
        wait_out(m);
        for (int v = 1; v <= 10; v++) begin
          chk("stream_valid", bus_u.out_valid, 1);
          chk("stream_y0", bus_u.y_out[0], 10*v);
          chk("stream_y3", bus_s.y_out[N-1], 10*v);
          tick();
        end
        chk("stream_end", bus_u.out_valid, 0);
      end
    join

    // weight row while busy: held off until the result emerges
    send_act(rnd_vec());
    wt_valid = 1'b1; wt_in = rnd_vec();
    chk("wt_blocked_busy", bus_u.wt_ready, 0);
    send_wt(wt_in);
    chk("reload_after_out", bus_u.out_valid, 0);
    for (int r = 1; r < N; r++) send_wt(rnd_vec());
    for (int i = 0; i < 6; i++) send_act(rnd_vec());
    repeat (12) tick();

    // partial load: compute blocked, then new weights used
    do_reset();
    load_kp1();
    send_wt(rnd_vec());
    send_wt(rnd_vec());
    act_valid = 1'b1; act_in = rnd_vec();
    tick();
    act_valid = 1'b0;
    chk("partial_drop_err", bus_u.err_drop, 1);
    send_wt(rnd_vec());
    send_wt(rnd_vec());
    for (int i = 0; i < 5; i++) send_act(rnd_vec());
    repeat (12) tick();

    // wrap / sign cases
    load_const(8'h80);
    send_act(splat(8'h80));
    wait_out(n);
    chk("u_80", bus_u.y_out[0], 65536);
    chk("s_80", bus_s.y_out[2], 65536);
    load_const(8'hFF);
    send_act(splat(8'hFF));
    wait_out(n);
    chk("u_ff", bus_u.y_out[1], 260100);
    chk("s_ff", bus_s.y_out[3], 4);
    repeat (2) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      wt_valid  = ($urandom_range(0, 99) < 8);
      wt_in     = rnd_vec();
      act_valid = ($urandom_range(0, 99) < 70);
      act_in    = rnd_vec();
      tick();
    end
    wt_valid = 0; act_valid = 0;
    repeat (12) tick();

    // reset with three vectors in flight
    do_reset();
    load_const(8'h03);
    send_act(rnd_vec());
    send_act(rnd_vec());
    send_act(rnd_vec());
    tick();
    rst_b = 1'b0;
    #1;
    chk("midrst_y", {bus_u.y_out, bus_s.y_out}, '0);
    chk("midrst_ctl", {bus_u.out_valid, bus_u.act_ready, bus_u.busy}, 3'b000);
    repeat (2) tick();
    rst_b = 1'b1;
    outs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_u.out_valid || bus_s.out_valid) outs++;
    end
    chk("midrst_no_out", outs, 0);
    chk("midrst_nowt", bus_u.act_ready, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
